// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control-code constants, sequencer state encodings and op-field positions.
// Used by the sequencer, the ALU and the decode unit.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int OP_MUL_BIT  = 3;
  localparam int OP_CTRL_MSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic ctrl_legal(input logic [2:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-and-add multiply state: accumulator, shifted multiplicand, multiplier and
// iteration counter. The add itself is done by the shared ALU (acc + mcand).
module alu_mul_iter #(
  parameter int DATA_W = 8,
  parameter int MUL_IT = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] mcand_in,
  input  logic [DATA_W-1:0] mplier_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] mcand,
  output logic [DATA_W-1:0] acc_nxt,
  output logic              done
);

  localparam int CNT_W = $clog2(MUL_IT + 1);

  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [CNT_W-1:0]  cnt_r;

  assign acc     = acc_r;
  assign mcand   = mcand_r;
  assign acc_nxt = mplier_r[0] ? alu_result : acc_r;
  assign done    = (cnt_r == CNT_W'(MUL_IT - 1));

  // One multiplier bit retired per step; the final edge is signalled by done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else if (load) begin
      acc_r    <= '0;
      mcand_r  <= mcand_in;
      mplier_r <= mplier_in;
      cnt_r    <= '0;
    end else if (step) begin
      acc_r    <= acc_nxt;
      mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      cnt_r    <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller for the shared ALU: request/response handshakes around one op at a time.
// Define ALU_MUL_SEQ_EN to build the multi-cycle multiply sequenced through ALU ADDs.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 3,
  parameter int MUL_IT = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  state_e            state_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              accept_s;
  logic              is_mul_s;
  logic              legal_s;

  assign accept_s = req_valid & req_ready;
  assign legal_s  = ~req_op[OP_MUL_BIT] & ctrl_legal(req_op[OP_CTRL_MSB:0]);

`ifdef ALU_MUL_SEQ_EN
  logic [DATA_W-1:0] mul_acc_s;
  logic [DATA_W-1:0] mul_mcand_s;
  logic [DATA_W-1:0] mul_acc_nxt_s;
  logic              mul_done_s;

  assign is_mul_s = req_op[OP_MUL_BIT];

  alu_mul_iter #(.DATA_W(DATA_W), .MUL_IT(MUL_IT)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s & is_mul_s),
    .step       (state_r == ST_MUL),
    .mcand_in   (req_a),
    .mplier_in  (req_b),
    .alu_result (alu_result),
    .acc        (mul_acc_s),
    .mcand      (mul_mcand_s),
    .acc_nxt    (mul_acc_nxt_s),
    .done       (mul_done_s)
  );

  // During a multiply the ALU adds acc + mcand; otherwise it sees the latched op.
  always_comb begin
    alu_ctrl = ctrl_r;
    alu_a    = a_r;
    alu_b    = b_r;
    if (state_r == ST_MUL) begin
      alu_ctrl = CTRL_W'(ALU_ADD);
      alu_a    = mul_acc_s;
      alu_b    = mul_mcand_s;
    end else begin
      alu_ctrl = ctrl_r;
      alu_a    = a_r;
      alu_b    = b_r;
    end
  end
`else
  assign is_mul_s = 1'b0;
  assign alu_ctrl = ctrl_r;
  assign alu_a    = a_r;
  assign alu_b    = b_r;
`endif

  // Sequencer FSM; ALU drive registers return to AND/0/0 outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      ctrl_r     <= CTRL_W'(ALU_AND);
      a_r        <= '0;
      b_r        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (is_mul_s) begin
              state_r <= ST_MUL;
            end else if (legal_s) begin
              state_r <= ST_EXEC;
              ctrl_r  <= req_op[CTRL_W-1:0];
              a_r     <= req_a;
              b_r     <= req_b;
            end else begin
              state_r    <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state_r    <= ST_RESP;
          ctrl_r     <= CTRL_W'(ALU_AND);
          a_r        <= '0;
          b_r        <= '0;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
`ifdef ALU_MUL_SEQ_EN
        ST_MUL: begin
          if (mul_done_s) begin
            state_r    <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= mul_acc_nxt_s;
            rsp_zero   <= (mul_acc_nxt_s == '0);
            rsp_err    <= 1'b0;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
